// File: rtl/float_to_fixed_ppl.sv
// float_to_fixed_ppl: 2-stage IEEE-754 single -> Q1.20 signed fixed-point.
// Stage 1 classifies the operand and right-aligns the significand.
// Stage 2 rounds, saturates symmetrically and applies the sign.
// A saturating counter tracks how many valid results were clipped.
// Optional feature macro: F2F_ROUND_NEAREST_EN (round-to-nearest-even).
// When it is undefined, results are truncated toward zero.
module float_to_fixed_ppl #(
    parameter int SAT_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 aclr,
    input  logic                 clk_en,
    input  logic                 valid_in,
    input  logic [31:0]          dataa,
    output logic [20:0]          fixed_out,
    output logic                 valid_out,
    output logic                 sat_out,
    output logic [SAT_CNT_W-1:0] sat_count
);

    localparam int STAGES = 2;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_SAT  = 2'd2
    } cls_e;

    typedef struct packed {
        logic        s;
        cls_e        cls;
        logic [19:0] mag;
`ifdef F2F_ROUND_NEAREST_EN
        logic        g;
        logic        st;
`endif
    } s1_t;

    // One valid bit per registered stage; the top bit drives valid_out.
    logic [STAGES:1] vld_pipe;
    s1_t             s1_q;
    s1_t             s1_d;

    // ---------------- stage 1 decode ----------------
    logic [7:0]  e;
    logic [23:0] sig;
    logic [4:0]  shamt;
`ifdef F2F_ROUND_NEAREST_EN
    logic [23:0] half;
`endif

    assign e   = dataa[30:23];
    assign sig = {1'b1, dataa[22:0]};

    // Classify the operand and align its significand onto the 20 fraction bits.
    always_comb begin
        s1_d     = '0;
        s1_d.s   = dataa[31];
        // Only meaningful for NORM (e in 106..126 gives 4..24).
        shamt    = 5'(8'd130 - e);
        if (e >= 8'd127) begin
            s1_d.cls = CLS_SAT;
        end else if (e <= 8'd105) begin
            s1_d.cls = CLS_ZERO;
        end else begin
            s1_d.cls = CLS_NORM;
            s1_d.mag = 20'(sig >> shamt);
        end
`ifdef F2F_ROUND_NEAREST_EN
        // Guard is the first bit shifted out; sticky ORs everything below it.
        half = 24'd1 << (shamt - 5'd1);
        if (s1_d.cls == CLS_NORM) begin
            s1_d.g  = |(sig & half);
            s1_d.st = |(sig & (half - 24'd1));
        end
`endif
    end

    // Stage 1 register: holds on stall, cleared by reset so in-flight data is dropped.
    always_ff @(posedge clock) begin
        if (aclr) begin
            s1_q        <= '0;
            vld_pipe[1] <= 1'b0;
        end else if (clk_en) begin
            s1_q        <= s1_d;
            vld_pipe[1] <= valid_in;
        end
    end

    // ---------------- stage 2 round / saturate / sign ----------------
    logic        inc;
    logic [20:0] r;
    logic [19:0] mag_f;
    logic        sat_c;
    logic [20:0] res;

    // Round, clip to +-0xFFFFF so 0x100000 never appears, then negate if needed.
    always_comb begin
`ifdef F2F_ROUND_NEAREST_EN
        inc = s1_q.g & (s1_q.st | s1_q.mag[0]);
`else
        inc = 1'b0;
`endif
        r     = {1'b0, s1_q.mag} + {20'd0, inc};
        mag_f = r[19:0];
        sat_c = 1'b0;
        case (s1_q.cls)
            CLS_SAT: begin
                mag_f = 20'hFFFFF;
                sat_c = 1'b1;
            end
            CLS_ZERO: begin
                mag_f = 20'd0;
            end
            default: begin
                if (r[20]) begin
                    mag_f = 20'hFFFFF;
                    sat_c = 1'b1;
                end
            end
        endcase
        // Negating zero wraps back to zero, so -0 comes out as 0.
        res = s1_q.s ? (~{1'b0, mag_f} + 21'd1) : {1'b0, mag_f};
    end

    // Output register and saturation counter; the counter sticks at all-ones.
    always_ff @(posedge clock) begin
        if (aclr) begin
            fixed_out   <= '0;
            sat_out     <= 1'b0;
            vld_pipe[2] <= 1'b0;
            sat_count   <= '0;
        end else if (clk_en) begin
            fixed_out   <= res;
            sat_out     <= sat_c;
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1] && sat_c && (sat_count != '1))
                sat_count <= sat_count + 1'b1;
        end
    end

    assign valid_out = vld_pipe[STAGES];

endmodule

// File: tb/tb_float_to_fixed_ppl.sv
// tb_float_to_fixed_ppl: directed test-plan cases plus randomized stimulus,
// all checked each cycle against a real-arithmetic reference model.
module tb_float_to_fixed_ppl;

    logic        clock = 1'b0;
    logic        aclr = 1'b1;
    logic        clk_en = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] dataa = '0;
    logic [20:0] fixed_out;
    logic        valid_out;
    logic        sat_out;
    logic [7:0]  sat_count;

    int n_cmp = 0;
    int n_bad = 0;

    float_to_fixed_ppl #(.SAT_CNT_W(8)) dut (
        .clock(clock), .aclr(aclr), .clk_en(clk_en), .valid_in(valid_in),
        .dataa(dataa), .fixed_out(fixed_out), .valid_out(valid_out),
        .sat_out(sat_out), .sat_count(sat_count)
    );

    always #5 clock = ~clock;

    // model state: stage-1 contents, output contents, saturation count
    logic        m1_v, m1_sat, mo_v, mo_sat;
    logic [20:0] m1_fx, mo_fx;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Value scaled by 2^20 in real arithmetic, then rounded/truncated and clipped.
    function automatic void ref_conv(input logic [31:0] d, output logic [20:0] fx,
                                     output logic sat);
        int     e;
        real    a, fr;
        longint mag;
        e = int'(d[30:23]);
        if (e == 0) a = real'(d[22:0]) * 2.0 ** (-129);
        else        a = real'({1'b1, d[22:0]}) * 2.0 ** (e - 130);
        sat = 1'b0;
        if (e == 255 || a >= 1048576.0) begin
            mag = 64'hFFFFF;
            sat = 1'b1;
        end else begin
            mag = longint'($rtoi(a));
            fr  = a - real'(mag);
`ifdef F2F_ROUND_NEAREST_EN
            if (fr > 0.5 || (fr == 0.5 && mag[0])) mag = mag + 1;
`endif
            if (mag >= 1048576) begin
                mag = 64'hFFFFF;
                sat = 1'b1;
            end
        end
        fx = d[31] ? 21'(-mag) : 21'(mag);
    endfunction

    // One clock: drive inputs, advance the model, then check every output.
    task automatic step(input logic en, input logic v, input logic [31:0] d,
                        input logic rst = 1'b0);
        logic [20:0] fx;
        logic        st;
        @(negedge clock);
        clk_en = en; valid_in = v; dataa = d; aclr = rst;
        @(posedge clock);
        if (rst) begin
            m1_v = 0; m1_sat = 0; m1_fx = '0;
            mo_v = 0; mo_sat = 0; mo_fx = '0; m_cnt = 0;
        end else if (en) begin
            if (m1_v && m1_sat && m_cnt < 255) m_cnt++;
            mo_v = m1_v; mo_sat = m1_sat; mo_fx = m1_fx;
            ref_conv(d, fx, st);
            m1_v = v; m1_sat = st; m1_fx = fx;
        end
        #1;
        chk("valid_out", 32'(valid_out), 32'(mo_v));
        chk("fixed_out", 32'(fixed_out), 32'(mo_fx));
        chk("sat_out",   32'(sat_out),   32'(mo_sat));
        chk("sat_count", 32'(sat_count), 32'(m_cnt));
    endtask

    // Feed one operand, flush it, and compare against a literal from the test plan.
    task automatic directed(input string tag, input logic [31:0] d,
                            input logic [20:0] efx, input logic esat);
        step(1, 1, d);
        step(1, 0, 32'h0);
        chk({tag, "_fx"}, 32'(fixed_out), 32'(efx));
        chk({tag, "_sat"}, 32'(sat_out), 32'(esat));
        chk({tag, "_vld"}, 32'(valid_out), 32'd1);
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] d;
        d = $urandom;
        case ($urandom_range(0, 3))
            0: ;
            1: d[30:23] = 8'($urandom_range(100, 128));
            2: begin d[30:23] = 8'd126; d[22:0] = 23'h7FFFFF - 23'($urandom_range(0, 3)); end
            default: d[30:23] = 8'($urandom_range(104, 126));
        endcase
        return d;
    endfunction

    initial begin
        m1_v = 0; m1_sat = 0; m1_fx = '0; mo_v = 0; mo_sat = 0; mo_fx = '0; m_cnt = 0;
        step(1, 0, 32'h0, 1'b1);
        step(0, 0, 32'h0, 1'b1);
        chk("rst_fx", 32'(fixed_out), 32'd0);
        chk("rst_vld", 32'(valid_out), 32'd0);

        // main function
`ifdef F2F_ROUND_NEAREST_EN
        directed("pi4", 32'h3F490FDB, 21'h0C90FE, 1'b0);
        directed("ovf", 32'h3F7FFFFF, 21'h0FFFFF, 1'b1);
`else
        directed("pi4", 32'h3F490FDB, 21'h0C90FD, 1'b0);
        directed("ovf", 32'h3F7FFFFF, 21'h0FFFFF, 1'b0);
`endif
        directed("half",  32'h3F000000, 21'h080000, 1'b0);
        directed("nhalf", 32'hBF000000, 21'h180000, 1'b0);
        directed("nzero", 32'h80000000, 21'h000000, 1'b0);
        directed("tiny",  32'h33000000, 21'h000000, 1'b0);

        // saturation and counter
        step(1, 0, 32'h0, 1'b1);
        directed("p15",  32'h3FC00000, 21'h0FFFFF, 1'b1);
        directed("n1",   32'hBF800000, 21'h100001, 1'b1);
        directed("nan",  32'h7FC00000, 21'h0FFFFF, 1'b1);
        chk("cnt3", 32'(sat_count), 32'd3);
        // invalid saturating operand must not count
        step(1, 0, 32'h7F800000);
        step(1, 0, 32'h0);
        chk("cnt_inv", 32'(sat_count), 32'd3);
        for (int i = 0; i < 300; i++) step(1, 1, 32'h3FC00000);
        step(1, 0, 32'h0);
        chk("cnt_max", 32'(sat_count), 32'hFF);

        // stall: 0.5, 0.25 then 5 stalled cycles, then 0.125
        step(1, 0, 32'h0, 1'b1);
        step(1, 1, 32'h3F000000);
        step(1, 1, 32'h3E800000);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 32'h3E000000);
            chk("stall_fx", 32'(fixed_out), 32'h080000);
        end
        step(1, 1, 32'h3E000000);
        chk("post1", 32'(fixed_out), 32'h040000);
        step(1, 0, 32'h0);
        chk("post2", 32'(fixed_out), 32'h020000);
        chk("post2_vld", 32'(valid_out), 32'd1);
        step(1, 0, 32'h0);
        chk("drain_vld", 32'(valid_out), 32'd0);

        // reset mid-stream
        step(1, 1, 32'h3FC00000);
        step(1, 1, 32'h3FC00000);
        step(1, 1, 32'h3E800000, 1'b1);
        chk("mrst_fx", 32'(fixed_out), 32'd0);
        chk("mrst_cnt", 32'(sat_count), 32'd0);
        step(1, 1, 32'h3F000000);
        chk("mrst_e1", 32'(valid_out), 32'd0);
        step(1, 0, 32'h0);
        chk("mrst_e2", 32'(fixed_out), 32'h080000);
        chk("mrst_e2v", 32'(valid_out), 32'd1);

        // randomized traffic with stalls and occasional resets
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 3) != 0), 1'($urandom), rnd_operand(),
                 ($urandom_range(0, 199) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
